// File: rtl/apb_master_port.sv
// apb_master_port: single-outstanding APB3 requester with valid/ready command and response channels.
// Aborts an ACCESS phase when PREADY stays low for more than TIMEOUT_CYCLES cycles.
module apb_master_port #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_write,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES));
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    state_d = req_valid ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (PREADY || timeout_hit) ? RESP : ACCESS;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = state == ACCESS;
    assign rsp_valid = state == RESP;
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE && req_valid) begin
                PADDR  <= req_addr;
                PWDATA <= req_wdata;
                PWRITE <= req_write;
                cnt    <= '0;
            end
            // PREADY takes priority over a timeout landing on the same cycle
            if (state == ACCESS) begin
                if (PREADY) begin
                    rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                    rsp_err     <= PSLVERR;
                    rsp_timeout <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_rdata   <= 32'h0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_master_port.sv
// tb_apb_master_port: table-driven APB transfers with a response scoreboard plus backpressure/reset sequences.
module tb_apb_master_port;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    logic        req_ready, rsp_valid, rsp_err, rsp_timeout, busy, PWRITE, PSEL, PENABLE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;
    int checks = 0, failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata, prdata;
        int          wt;
        logic        slverr;
        logic [31:0] x_rdata;
        logic        x_err, x_to;
        int          x_lat;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err, to;
    } exp_t;
    exp_t exp_q[$];
    vec_t vecs[7];

    apb_master_port #(.APB_ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    // Scoreboard: pop on each completed response handshake
    always @(negedge HCLK) begin
        if (!HRESET && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_timeout", rsp_timeout, e.to);
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int lat, acc;
        logic ok;
        lat = 0;
        acc = 0;
        ok = 1'b1;
        chk($sformatf("idle_gap_%0d", idx), {req_ready, busy, PSEL}, 3'b100);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        rsp_ready = 1'b1;
        exp_q.push_back('{v.x_rdata, v.x_err, v.x_to});
        step;
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            if (rsp_valid) begin
                lat = c;
            end else begin
                if (PSEL !== 1'b1 || PENABLE !== (c > 1) || PADDR !== v.addr ||
                    PWRITE !== v.wr || PWDATA !== v.wdata) ok = 1'b0;
                PREADY  = PENABLE && (acc >= v.wt);
                PRDATA  = PREADY ? v.prdata : $urandom;
                PSLVERR = PREADY ? v.slverr : 1'b0;
                acc += int'(PENABLE);
                step;
                PREADY = 1'b0;
            end
        end
        chk($sformatf("phase_shape_%0d", idx), ok, 1);
        chk($sformatf("latency_%0d", idx), lat, v.x_lat);
        chk($sformatf("resp_bus_idle_%0d", idx), {PSEL, PENABLE}, 0);
        step;
        chk($sformatf("rsp_drop_%0d", idx), {rsp_valid, busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr    addr          wdata          prdata        wt  err   x_rdata        x_err x_to  lat
        vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h1234_5678, 0,  1'b0, 32'h0,         1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h1111_1111, 32'h0000_00A5, 3,  1'b0, 32'h0000_00A5, 1'b0, 1'b0, 6};
        vecs[2] = '{1'b0, 32'h0000_0014, 32'h0,         32'h5A5A_0001, 0,  1'b1, 32'h5A5A_0001, 1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_FFFF, 99, 1'b0, 32'h0,         1'b1, 1'b1, 7};
        vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         32'h00C0_FFEE, 4,  1'b0, 32'h00C0_FFEE, 1'b0, 1'b0, 7};
        vecs[5] = '{1'b1, 32'h0000_0028, 32'hCAFE_F00D, 32'h7777_7777, 2,  1'b1, 32'h0,         1'b1, 1'b0, 5};
        vecs[6] = '{1'b1, 32'h0000_002C, 32'h0BAD_0BAD, 32'h6666_6666, 99, 1'b0, 32'h0,         1'b1, 1'b1, 7};

        step;
        step;
        chk("reset_outputs", {PSEL, PENABLE, rsp_valid, busy, PWRITE, rsp_err, rsp_timeout}, 0);
        chk("reset_data", {PADDR, PWDATA | rsp_rdata}, 0);
        HRESET = 1'b0;
        step;
        chk("reset_req_ready", req_ready, 1);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Response backpressure with an ignored command pending
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h30;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        exp_q.push_back('{32'h77, 1'b0, 1'b0});
        step;
        req_addr = 32'hBAD;
        step;
        PREADY = 1'b1;
        PRDATA = 32'h77;
        step;
        PREADY = 1'b0;
        PRDATA = 32'h0;
        chk("bp_rsp_valid", rsp_valid, 1);
        begin
            logic ok;
            ok = 1'b1;
            for (int c = 0; c < 10; c++) begin
                if (!rsp_valid || rsp_rdata !== 32'h77 || rsp_err || rsp_timeout ||
                    req_ready || !busy || PSEL || PADDR !== 32'h30) ok = 1'b0;
                step;
            end
            chk("bp_hold_stable", ok, 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step;
        chk("bp_release", {rsp_valid, busy, req_ready}, 3'b001);

        // Reset mid-ACCESS discards the transfer
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h4040_4040;
        step;
        req_valid = 1'b0;
        step;
        chk("rst_in_access", {PSEL, PENABLE}, 2'b11);
        HRESET = 1'b1;
        step;
        chk("rst_mid_access", {PSEL, PENABLE, rsp_valid, busy}, 0);
        HRESET = 1'b0;
        step;
        chk("rst_req_ready", {req_ready, busy}, 2'b10);

        run_vec(7, vecs[1]);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
